// File: rtl/axi_lite_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_bridge_if
// Brief    : AXI4 single-beat channel bundle between the bridge and a slave.
// Revision : 1.0
// ============================================================================
interface axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [3:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [3:0]          RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [3:0]          AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [3:0]          BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_bridge
// Brief    : Single-request memory port to single-beat AXI4 master bridge.
// Revision : 1.0
// ============================================================================
module axi_lite_master_bridge #(
    parameter logic [3:0] ID_VAL = 4'd0,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                req,
    input  wire logic                we,
    input  wire logic [ADDR_W-1:0]   addr,
    input  wire logic [DATA_W-1:0]   wdata,
    input  wire logic [DATA_W/8-1:0] wstrb,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               resp,
    output logic                     err,
    axi_lite_master_bridge_if.master axi
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RADDR = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_WRESP = 3'd4;

    logic [2:0]          r_state;
    logic                r_aw_done;
    logic                r_w_done;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_resp;

    logic w_awvalid;
    logic w_wvalid;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_unused;

    // Valids/readies decode straight from flops only, so reset drops them at once
    assign w_awvalid = (r_state == S_WRITE) & ~r_aw_done;
    assign w_wvalid  = (r_state == S_WRITE) & ~r_w_done;
    assign w_aw_hs   = w_awvalid & axi.AWREADY;
    assign w_w_hs    = w_wvalid & axi.WREADY;
    assign w_unused  = ^{axi.RID, axi.RLAST, axi.BID};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_done    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_wstrb <= wstrb;
                        r_state <= we ? S_WRITE : S_RADDR;
                    end
                end
                S_RADDR: begin
                    if (axi.ARREADY) r_state <= S_RDATA;
                end
                S_RDATA: begin
                    if (axi.RVALID) begin
                        r_rdata <= axi.RDATA;
                        r_resp  <= axi.RRESP;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    // Either channel may finish last, including both in one cycle
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= S_WRESP;
                end
                S_WRESP: begin
                    if (axi.BVALID) begin
                        r_resp    <= axi.BRESP;
                        r_done    <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign axi.ARID    = ID_VAL;
    assign axi.ARADDR  = r_addr;
    assign axi.ARLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = (r_state == S_RADDR);
    assign axi.RREADY  = (r_state == S_RDATA);

    assign axi.AWID    = ID_VAL;
    assign axi.AWADDR  = r_addr;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = w_awvalid;
    assign axi.WDATA   = r_wdata;
    assign axi.WSTRB   = r_wstrb;
    assign axi.WLAST   = 1'b1;
    assign axi.WVALID  = w_wvalid;
    assign axi.BREADY  = (r_state == S_WRESP);

    assign busy  = (r_state != S_IDLE) | r_done;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign resp  = r_resp;
    assign err   = r_done & (r_resp != 2'b00);
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master_bridge
// Brief    : Directed testbench for axi_lite_master_bridge.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_master_bridge;
    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        err;

    int passed = 0;
    int total  = 0;
    int ar_cnt = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;
    int done_cnt = 0;

    axi_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi();

    axi_lite_master_bridge #(.ID_VAL(4'd0), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .busy(busy), .done(done), .rdata(rdata), .resp(resp),
        .err(err), .axi(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake tallies, sampled at the edge that completes each beat
    always @(posedge clk) begin
        if (axi.ARVALID && axi.ARREADY) ar_cnt++;
        if (axi.AWVALID && axi.AWREADY) aw_cnt++;
        if (axi.WVALID && axi.WREADY)   w_cnt++;
        if (done)                       done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(); tick();
        total++; if (axi.ARVALID !== 1'b0) $display("FAIL rst_arvalid got=%b exp=0", axi.ARVALID); else passed++;
        total++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0) $display("FAIL rst_aw_w_valid got=%b%b exp=00", axi.AWVALID, axi.WVALID); else passed++;
        total++; if (axi.RREADY !== 1'b0 || axi.BREADY !== 1'b0) $display("FAIL rst_readies got=%b%b exp=00", axi.RREADY, axi.BREADY); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL rst_status got=%b%b%b exp=000", busy, done, err); else passed++;
        total++; if (rdata !== 32'h0 || resp !== 2'b00) $display("FAIL rst_rdata_resp got=%h/%b exp=0/00", rdata, resp); else passed++;
        total++; if (axi.ARADDR !== 32'h0 || axi.WDATA !== 32'h0) $display("FAIL rst_payload got=%h/%h exp=0/0", axi.ARADDR, axi.WDATA); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
        tick();                                         // T1
        req = 1'b0;
        total++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h100) $display("FAIL rd_ar_t1 got=%b/%h exp=1/00000100", axi.ARVALID, axi.ARADDR); else passed++;
        total++; if ({axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST} !== {4'd0, 4'd0, 3'b010, 2'b01}) $display("FAIL rd_ar_consts got=%h/%h/%b/%b exp=0/0/010/01", axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rd_busy_t1 got=%b exp=1", busy); else passed++;
        axi.ARREADY = 1'b1;
        tick();                                         // T2
        axi.ARREADY = 1'b0;
        total++; if (axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b1) $display("FAIL rd_t2 got=arvalid %b rready %b exp=0/1", axi.ARVALID, axi.RREADY); else passed++;
        axi.RVALID = 1'b1; axi.RDATA = 32'hDEAD_BEEF; axi.RRESP = 2'b00;
        tick();                                         // T3
        axi.RVALID = 1'b0; axi.RDATA = 32'h0;
        total++; if (done !== 1'b1 || rdata !== 32'hDEAD_BEEF) $display("FAIL rd_done_t3 got=%b/%h exp=1/deadbeef", done, rdata); else passed++;
        total++; if (err !== 1'b0 || resp !== 2'b00 || busy !== 1'b1) $display("FAIL rd_status_t3 got=err %b resp %b busy %b exp=0/00/1", err, resp, busy); else passed++;
        tick();                                         // T4
        total++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'hDEAD_BEEF) $display("FAIL rd_t4 got=%b/%b/%h exp=0/0/deadbeef", done, busy, rdata); else passed++;
    endtask

    task automatic test_write_aw_first;
        int d0 = done_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0200; wdata = 32'h1234_5678; wstrb = 4'hF;
        tick();                                         // T1
        req = 1'b0;
        total++; if (axi.AWVALID !== 1'b1 || axi.WVALID !== 1'b1) $display("FAIL wa_valids_t1 got=%b%b exp=11", axi.AWVALID, axi.WVALID); else passed++;
        total++; if (axi.AWADDR !== 32'h200 || axi.WDATA !== 32'h1234_5678 || axi.WSTRB !== 4'hF || axi.WLAST !== 1'b1) $display("FAIL wa_payload got=%h/%h/%h/%b exp=200/12345678/f/1", axi.AWADDR, axi.WDATA, axi.WSTRB, axi.WLAST); else passed++;
        axi.AWREADY = 1'b1;
        tick();                                         // T2
        axi.AWREADY = 1'b0;
        total++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b1) $display("FAIL wa_t2 got=%b%b exp=01", axi.AWVALID, axi.WVALID); else passed++;
        tick();                                         // T3
        total++; if (axi.WVALID !== 1'b1 || axi.BREADY !== 1'b0) $display("FAIL wa_t3 got=wvalid %b bready %b exp=1/0", axi.WVALID, axi.BREADY); else passed++;
        tick();                                         // T4
        total++; if (axi.WVALID !== 1'b1) $display("FAIL wa_wvalid_t4 got=%b exp=1", axi.WVALID); else passed++;
        axi.WREADY = 1'b1;
        tick();                                         // T5
        axi.WREADY = 1'b0;
        total++; if (axi.WVALID !== 1'b0 || axi.BREADY !== 1'b1 || done !== 1'b0) $display("FAIL wa_t5 got=%b/%b/%b exp=0/1/0", axi.WVALID, axi.BREADY, done); else passed++;
        tick();                                         // T6
        total++; if (axi.BREADY !== 1'b1) $display("FAIL wa_bready_t6 got=%b exp=1", axi.BREADY); else passed++;
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        tick();                                         // T7
        axi.BVALID = 1'b0;
        total++; if (done !== 1'b1 || resp !== 2'b00 || err !== 1'b0) $display("FAIL wa_done_t7 got=%b/%b/%b exp=1/00/0", done, resp, err); else passed++;
        tick();
        total++; if (done_cnt - d0 !== 1) $display("FAIL wa_done_count got=%0d exp=1", done_cnt - d0); else passed++;
    endtask

    task automatic test_write_w_first;
        int aw0 = aw_cnt; int w0 = w_cnt; int d0 = done_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0300; wdata = 32'hA5A5_A5A5; wstrb = 4'h3;
        tick();                                         // T1
        req = 1'b0; axi.WREADY = 1'b1;
        tick();                                         // T2
        axi.WREADY = 1'b0;
        total++; if (axi.WVALID !== 1'b0 || axi.AWVALID !== 1'b1 || axi.AWADDR !== 32'h300) $display("FAIL wf_t2 got=%b/%b/%h exp=0/1/300", axi.WVALID, axi.AWVALID, axi.AWADDR); else passed++;
        tick();                                         // T3
        axi.AWREADY = 1'b1;
        tick();                                         // T4
        axi.AWREADY = 1'b0;
        total++; if (axi.AWVALID !== 1'b0 || axi.BREADY !== 1'b1) $display("FAIL wf_t4 got=%b/%b exp=0/1", axi.AWVALID, axi.BREADY); else passed++;
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        tick();                                         // T5
        axi.BVALID = 1'b0;
        total++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL wf_done got=%b/%b exp=1/0", done, err); else passed++;
        tick(); tick();
        total++; if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 || done_cnt - d0 !== 1) $display("FAIL wf_beats got=aw %0d w %0d done %0d exp=1/1/1", aw_cnt - aw0, w_cnt - w0, done_cnt - d0); else passed++;
    endtask

    task automatic test_write_same_cycle;
        int aw0 = aw_cnt; int w0 = w_cnt; int d0 = done_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0400; wdata = 32'h0F0F_0F0F; wstrb = 4'hC;
        tick();                                         // T1
        req = 1'b0; axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        total++; if (axi.WSTRB !== 4'hC || axi.WLAST !== 1'b1) $display("FAIL ws_strb got=%h/%b exp=c/1", axi.WSTRB, axi.WLAST); else passed++;
        tick();                                         // T2
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        total++; if (axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0 || axi.BREADY !== 1'b1) $display("FAIL ws_t2 got=%b%b%b exp=001", axi.AWVALID, axi.WVALID, axi.BREADY); else passed++;
        axi.BVALID = 1'b1; axi.BRESP = 2'b10;
        tick();                                         // T3
        axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        total++; if (done !== 1'b1 || resp !== 2'b10 || err !== 1'b1) $display("FAIL ws_slverr got=%b/%b/%b exp=1/10/1", done, resp, err); else passed++;
        tick(); tick();
        total++; if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1 || done_cnt - d0 !== 1) $display("FAIL ws_beats got=aw %0d w %0d done %0d exp=1/1/1", aw_cnt - aw0, w_cnt - w0, done_cnt - d0); else passed++;
        total++; if (err !== 1'b0) $display("FAIL ws_err_after got=%b exp=0", err); else passed++;
    endtask

    task automatic test_decerr;
        req = 1'b1; we = 1'b0; addr = 32'hF000_0000;
        tick();                                         // T1
        req = 1'b0; axi.ARREADY = 1'b1;
        tick();                                         // T2
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RRESP = 2'b11; axi.RDATA = 32'h0;
        tick();                                         // T3
        axi.RVALID = 1'b0; axi.RRESP = 2'b00;
        total++; if (done !== 1'b1 || resp !== 2'b11 || err !== 1'b1 || rdata !== 32'h0) $display("FAIL de_read got=%b/%b/%b/%h exp=1/11/1/0", done, resp, err, rdata); else passed++;
        req = 1'b1; we = 1'b1; addr = 32'hF000_0004; wdata = 32'h1111_2222; wstrb = 4'hF;
        tick();                                         // T1 (accepted in done cycle)
        req = 1'b0; axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        tick();                                         // T2
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b1; axi.BRESP = 2'b11;
        tick();                                         // T3
        axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        total++; if (done !== 1'b1 || resp !== 2'b11 || err !== 1'b1) $display("FAIL de_write got=%b/%b/%b exp=1/11/1", done, resp, err); else passed++;
        tick();
    endtask

    task automatic test_backpressure;
        int ar0 = ar_cnt; int aw0 = aw_cnt; int d0 = done_cnt;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0440;
        tick();                                         // T1
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h440) $display("FAIL bp_hold_%0d got=%b/%h exp=1/440", i, axi.ARVALID, axi.ARADDR); else passed++;
            req = (i == 1 || i == 2); we = 1'b1; addr = 32'h0000_0999;
            tick();
        end
        req = 1'b0;
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RDATA = 32'h55AA_00FF; axi.RRESP = 2'b00;
        tick();
        axi.RVALID = 1'b0; axi.RDATA = 32'h0;
        total++; if (done !== 1'b1 || rdata !== 32'h55AA_00FF) $display("FAIL bp_done got=%b/%h exp=1/55aa00ff", done, rdata); else passed++;
        tick(); tick();
        total++; if (ar_cnt - ar0 !== 1 || aw_cnt - aw0 !== 0 || done_cnt - d0 !== 1) $display("FAIL bp_counts got=ar %0d aw %0d done %0d exp=1/0/1", ar_cnt - ar0, aw_cnt - aw0, done_cnt - d0); else passed++;
    endtask

    task automatic test_back_to_back;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
        tick();                                         // T1
        req = 1'b0; axi.ARREADY = 1'b1;
        tick();                                         // T2
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RDATA = 32'h0000_1111;
        tick();                                         // T3 done cycle
        axi.RVALID = 1'b0;
        total++; if (done !== 1'b1 || rdata !== 32'h0000_1111) $display("FAIL b2b_first got=%b/%h exp=1/00001111", done, rdata); else passed++;
        req = 1'b1; addr = 32'h0000_0020;
        tick();                                         // T4
        req = 1'b0;
        total++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h20 || done !== 1'b0) $display("FAIL b2b_reissue got=%b/%h/%b exp=1/20/0", axi.ARVALID, axi.ARADDR, done); else passed++;
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RDATA = 32'hCAFE_F00D;
        tick();
        axi.RVALID = 1'b0; axi.RDATA = 32'h0;
        total++; if (done !== 1'b1 || rdata !== 32'hCAFE_F00D) $display("FAIL b2b_second got=%b/%h exp=1/cafef00d", done, rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt;
        req = 1'b1; we = 1'b1; addr = 32'h0000_0600; wdata = 32'h7777_8888; wstrb = 4'hF;
        tick();                                         // T1
        req = 1'b0; axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
        tick();                                         // T2 in WRESP
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        total++; if (axi.BREADY !== 1'b1) $display("FAIL rm_wresp got=%b exp=1", axi.BREADY); else passed++;
        axi.BVALID = 1'b1; axi.BRESP = 2'b00;
        #3 rst = 1'b0;
        #1;
        total++; if (axi.BREADY !== 1'b0 || axi.AWVALID !== 1'b0 || axi.WVALID !== 1'b0 || axi.ARVALID !== 1'b0 || axi.RREADY !== 1'b0) $display("FAIL rm_async got=b%b aw%b w%b ar%b r%b exp=all 0", axi.BREADY, axi.AWVALID, axi.WVALID, axi.ARVALID, axi.RREADY); else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rm_status got=%b/%b exp=0/0", busy, done); else passed++;
        @(posedge clk); #1;
        rst = 1'b1; axi.BVALID = 1'b0;
        tick(); tick();
        total++; if (done_cnt !== d0 || busy !== 1'b0 || resp !== 2'b00) $display("FAIL rm_no_done got=%0d/%b/%b exp=%0d/0/00", done_cnt, busy, resp, d0); else passed++;
        req = 1'b1; we = 1'b0; addr = 32'h0000_0700;
        tick();
        req = 1'b0;
        total++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h700) $display("FAIL rm_read_ar got=%b/%h exp=1/700", axi.ARVALID, axi.ARADDR); else passed++;
        axi.ARREADY = 1'b1;
        tick();
        axi.ARREADY = 1'b0; axi.RVALID = 1'b1; axi.RDATA = 32'h0BAD_CAFE;
        tick();
        axi.RVALID = 1'b0; axi.RDATA = 32'h0;
        total++; if (done !== 1'b1 || rdata !== 32'h0BAD_CAFE || err !== 1'b0) $display("FAIL rm_read_done got=%b/%h/%b exp=1/0badcafe/0", done, rdata, err); else passed++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        axi.ARREADY = 1'b0; axi.RID = 4'd0; axi.RDATA = '0; axi.RRESP = 2'b00;
        axi.RLAST = 1'b1; axi.RVALID = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
        axi.BID = 4'd0; axi.BRESP = 2'b00; axi.BVALID = 1'b0;
        test_reset();
        test_read();
        test_write_aw_first();
        test_write_w_first();
        test_write_same_cycle();
        test_decerr();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
